// File: rtl/mcpu_cache_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : mcpu_cache_rom_arb
// Description : Round-robin arbiter sharing one synchronous boot ROM
//               (256-bit atoms, 1-cycle read latency) between the fetch
//               port and the data-side ROM port. Returns 128-bit half-atom
//               packets with a 1-cycle completion pulse. Pipelined so two
//               requesters can alternate with a ROM read every cycle.
// Option      : MCPU_ROM_ARB_OOR_EN - when defined, requests above the ROM
//               size suppress the ROM read, return a zero packet and set
//               the sticky arb_oor_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mcpu_cache_rom_arb #(
    parameter int ROM_SIZE   = 2048,
    parameter int ROM_ATOMS  = ROM_SIZE / 32,
    parameter int ROMAD_BITS = $clog2(ROM_ATOMS - 1)
) (
    input  logic                  clkrst_core_clk,
    input  logic                  clkrst_core_rst_n,
    input  logic                  f2ic_valid,
    input  logic [27:0]           f2ic_paddr,
    output logic                  ic2f_ready,
    output logic [127:0]          ic2f_packet,
    input  logic                  d2rom_valid,
    input  logic [27:0]           d2rom_paddr,
    output logic                  rom2d_ready,
    output logic [127:0]          rom2d_packet,
    output logic                  rom_re,
    output logic [ROMAD_BITS-1:0] rom_addr,
    input  logic [255:0]          rom_q,
    output logic                  arb_oor_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Requester ids used for the outstanding-grant and last-grant registers
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    state_e state_q, state_d;
    logic   grant_id_q, grant_id_d;   // requester answered in BUSY
    logic   half_q, half_d;           // atom half selected for the answer
    logic   oor_q, oor_d;             // outstanding read was out of range
    logic   last_grant_q, last_grant_d;
    logic   err_q, err_d;

    logic        elig_f, elig_d;
    logic        grant, win_id;
    logic [27:0] win_paddr;
    logic        win_oor;
    logic [127:0] resp_packet;

    // Eligibility, round-robin winner selection and address steering
    always_comb begin
        // While answering a requester its valid is still high; it must not
        // be re-issued in the same cycle.
        elig_f = f2ic_valid  && !((state_q == ST_BUSY) && (grant_id_q == REQ_FETCH));
        elig_d = d2rom_valid && !((state_q == ST_BUSY) && (grant_id_q == REQ_DATA));
        grant  = elig_f || elig_d;
        if (elig_f && elig_d) begin
            win_id = (last_grant_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
        end else begin
            win_id = elig_d ? REQ_DATA : REQ_FETCH;
        end
        win_paddr = (win_id == REQ_DATA) ? d2rom_paddr : f2ic_paddr;
    end

`ifdef MCPU_ROM_ARB_OOR_EN
    assign win_oor = |win_paddr[27:ROMAD_BITS+1];
`else
    // Upper address bits alias modulo the ROM size
    logic unused_upper_bits;
    assign unused_upper_bits = |win_paddr[27:ROMAD_BITS+1];
    assign win_oor = 1'b0;
`endif

    // Next-state, ROM request and response outputs
    always_comb begin
        state_d      = ST_IDLE;
        grant_id_d   = grant_id_q;
        half_d       = half_q;
        oor_d        = oor_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        rom_re       = 1'b0;
        rom_addr     = '0;
        ic2f_ready   = 1'b0;
        rom2d_ready  = 1'b0;
        ic2f_packet  = '0;
        rom2d_packet = '0;

        resp_packet = half_q ? rom_q[255:128] : rom_q[127:0];
        if (oor_q) begin
            resp_packet = '0;
        end

        if (state_q == ST_BUSY) begin
            if (grant_id_q == REQ_FETCH) begin
                ic2f_ready  = 1'b1;
                ic2f_packet = resp_packet;
            end else begin
                rom2d_ready  = 1'b1;
                rom2d_packet = resp_packet;
            end
        end

        if (grant) begin
            rom_re       = !win_oor;
            rom_addr     = win_paddr[ROMAD_BITS:1];
            state_d      = ST_BUSY;
            grant_id_d   = win_id;
            half_d       = win_paddr[0];
            oor_d        = win_oor;
            last_grant_d = win_id;
            err_d        = err_q | win_oor;
        end
    end

    assign arb_oor_err = err_q;

    // State and grant bookkeeping registers
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= REQ_FETCH;
            half_q       <= 1'b0;
            oor_q        <= 1'b0;
            last_grant_q <= REQ_DATA;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            half_q       <= half_d;
            oor_q        <= oor_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

`ifndef SYNTHESIS
    logic [27:0] chk_paddr_q;

    // Remember the granted address so the protocol check can compare it
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            chk_paddr_q <= '0;
        end else if (grant) begin
            chk_paddr_q <= win_paddr;
        end
    end

    // Requester must hold valid and paddr until its ready pulse
    always @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst_n && (state_q == ST_BUSY)) begin
            if (grant_id_q == REQ_FETCH) begin
                assert (f2ic_valid && (f2ic_paddr == chk_paddr_q));
            end else begin
                assert (d2rom_valid && (d2rom_paddr == chk_paddr_q));
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcpu_cache_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcpu_cache_rom_arb
// Description : Directed self-checking bench for mcpu_cache_rom_arb with a
//               behavioural 1-cycle-latency ROM. Honours MCPU_ROM_ARB_OOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_cache_rom_arb;

    logic         clk;
    logic         rst_n;
    logic         fv, dv;
    logic [27:0]  fp, dp;
    logic         f_rdy, d_rdy;
    logic [127:0] f_pkt, d_pkt;
    logic         rom_re;
    logic [5:0]   rom_addr;
    logic [255:0] rom_q;
    logic         oor_err;

    int n_cmp = 0;
    int n_bad = 0;

    mcpu_cache_rom_arb dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst_n (rst_n),
        .f2ic_valid        (fv),
        .f2ic_paddr        (fp),
        .ic2f_ready        (f_rdy),
        .ic2f_packet       (f_pkt),
        .d2rom_valid       (dv),
        .d2rom_paddr       (dp),
        .rom2d_ready       (d_rdy),
        .rom2d_packet      (d_pkt),
        .rom_re            (rom_re),
        .rom_addr          (rom_addr),
        .rom_q             (rom_q),
        .arb_oor_err       (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Atom contents: word k of atom a is C0DE_aa_kk
    function automatic logic [255:0] atom(input int a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = {16'hC0DE, a[7:0], k[7:0]};
        end
        return r;
    endfunction

    // Expected 128-bit packet for a 16-byte paddr
    function automatic logic [127:0] pkt(input int p);
        logic [255:0] a;
        a = atom((p >> 1) & 63);
        return p[0] ? a[255:128] : a[127:0];
    endfunction

    // Behavioural synchronous ROM
    always_ff @(posedge clk) begin
        if (rom_re) begin
            rom_q <= atom(int'(rom_addr));
        end
    end
    initial rom_q = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge of the next cycle
    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    int fa, da, pf, pd;

    initial begin
        rst_n = 1'b0; fv = 1'b0; dv = 1'b0; fp = '0; dp = '0;

        // Reset state
        @(negedge clk); #1;
        check("rst_f_rdy", f_rdy, 0);
        check("rst_d_rdy", d_rdy, 0);
        check("rst_f_pkt", f_pkt, 0);
        check("rst_d_pkt", d_pkt, 0);
        check("rst_re",    rom_re, 0);
        check("rst_addr",  rom_addr, 0);
        check("rst_err",   oor_err, 0);

        // Both valid in the first cycle after reset: fetch wins the tie
        nxt();
        rst_n = 1'b1; fv = 1'b1; fp = 28'd0; dv = 1'b1; dp = 28'd4;
        #1;
        check("t2_re0",   rom_re, 1);
        check("t2_addr0", rom_addr, 0);
        check("t2_frdy0", f_rdy, 0);
        nxt(); #1;
        check("t2_frdy1", f_rdy, 1);
        check("t2_fpkt1", f_pkt, pkt(0));
        check("t2_drdy1", d_rdy, 0);
        check("t2_re1",   rom_re, 1);
        check("t2_addr1", rom_addr, 2);
        nxt(); fv = 1'b0; #1;
        check("t2_drdy2", d_rdy, 1);
        check("t2_dpkt2", d_pkt, pkt(4));
        check("t2_frdy2", f_rdy, 0);
        check("t2_re2",   rom_re, 0);
        nxt(); dv = 1'b0; #1;
        check("t2_drdy3", d_rdy, 0);

        // Fetch only, paddr 7 -> atom 3 upper half
        nxt(); fv = 1'b1; fp = 28'd7; #1;
        check("t1_re",   rom_re, 1);
        check("t1_addr", rom_addr, 3);
        nxt(); #1;
        check("t1_frdy", f_rdy, 1);
        check("t1_fpkt", f_pkt, pkt(7));
        check("t1_drdy", d_rdy, 0);
        check("t1_dpkt", d_pkt, 0);
        check("t1_re1",  rom_re, 0);
        nxt(); fv = 1'b0; #1;
        check("t1_frdy2", f_rdy, 0);

        // Data only, four sequential requests: ready every second cycle
        for (int i = 0; i < 4; i++) begin
            nxt(); dv = 1'b1; dp = 28'(i); #1;
            check("t4_drdy_lo", d_rdy, 0);
            check("t4_re",      rom_re, 1);
            check("t4_addr",    rom_addr, 6'(i >> 1));
            nxt(); #1;
            check("t4_drdy", d_rdy, 1);
            check("t4_dpkt", d_pkt, pkt(i));
            check("t4_re_b", rom_re, 0);
        end
        nxt(); dv = 1'b0; #1;
        check("t4_idle_re", rom_re, 0);

        // Both continuously valid: ROM read every cycle, strict alternation.
        // Last grant was data, so fetch goes first.
        fa = 10; da = 21; pf = 0; pd = 0;
        for (int k = 0; k < 8; k++) begin
            nxt();
            fv = 1'b1; fp = 28'(fa); dv = 1'b1; dp = 28'(da);
            #1;
            check("t3_re", rom_re, 1);
            check("t3_addr", rom_addr, 6'(((k % 2) == 0) ? (fa >> 1) : (da >> 1)));
            if (k % 2 == 1) begin
                check("t3_frdy", f_rdy, 1);
                check("t3_fpkt", f_pkt, pkt(pf));
                check("t3_drdy0", d_rdy, 0);
            end else if (k > 0) begin
                check("t3_drdy", d_rdy, 1);
                check("t3_dpkt", d_pkt, pkt(pd));
                check("t3_frdy0", f_rdy, 0);
            end
            if (k % 2 == 0) pf = fa; else pd = da;
            if (k % 2 == 1) fa = fa + 3;
            if ((k % 2 == 0) && (k > 0)) da = da + 5;
        end
        nxt(); fv = 1'b0; #1;
        check("t3_drdy_end", d_rdy, 1);
        check("t3_dpkt_end", d_pkt, pkt(pd));
        check("t3_re_end",   rom_re, 0);
        nxt(); dv = 1'b0; #1;
        check("t3_idle", d_rdy, 0);

        // Reset asserted while BUSY: the outstanding read is dropped
        nxt(); fv = 1'b1; fp = 28'd2; #1;
        check("t5_re",   rom_re, 1);
        check("t5_addr", rom_addr, 1);
        nxt(); rst_n = 1'b0; fv = 1'b0; #1;
        check("t5_frdy0", f_rdy, 0);
        check("t5_fpkt0", f_pkt, 0);
        check("t5_re0",   rom_re, 0);
        nxt(); #1;
        check("t5_frdy1", f_rdy, 0);
        check("t5_drdy1", d_rdy, 0);
        nxt(); rst_n = 1'b1; #1;
        check("t5_frdy2", f_rdy, 0);
        check("t5_drdy2", d_rdy, 0);
        check("t5_re2",   rom_re, 0);
        nxt(); #1;
        check("t5_frdy3", f_rdy, 0);
        check("t5_err",   oor_err, 0);

        // Address beyond the ROM size
        nxt(); fv = 1'b1; fp = 28'h100; #1;
`ifdef MCPU_ROM_ARB_OOR_EN
        check("t6_re", rom_re, 0);
`else
        check("t6_re",   rom_re, 1);
        check("t6_addr", rom_addr, 0);
`endif
        nxt(); #1;
        check("t6_frdy", f_rdy, 1);
`ifdef MCPU_ROM_ARB_OOR_EN
        check("t6_fpkt", f_pkt, 0);
        check("t6_err",  oor_err, 1);
`else
        check("t6_fpkt", f_pkt, pkt(0));
        check("t6_err",  oor_err, 0);
`endif
        nxt(); fv = 1'b0; #1;
        nxt(); fv = 1'b1; fp = 28'd5; #1;
        check("t6_re2",   rom_re, 1);
        check("t6_addr2", rom_addr, 2);
        nxt(); #1;
        check("t6_fpkt2", f_pkt, pkt(5));
`ifdef MCPU_ROM_ARB_OOR_EN
        check("t6_err_sticky", oor_err, 1);
`else
        check("t6_err_tied", oor_err, 0);
`endif
        nxt(); fv = 1'b0; #1;
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
